// File: rtl/sigmoid_out_fifo.sv
// Output buffer for the sigmoid stage: a small first-word-fall-through FIFO with a
// valid/ready drain, occupancy, sticky overflow and a constant transistor tally.
module sigmoid_out_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_in_valid,
  input  logic [DW-1:0] i_y,
  input  logic          i_flush,
  input  logic          i_out_ready,
  output logic [DW-1:0] o_y,
  output logic          o_out_valid,
  output logic [CW-1:0] o_count,
  output logic          o_overflow,
  output logic [50:0]   number
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Transistor cost of each cell type used in the tally below.
  localparam int T_DFF   = 24;
  localparam int T_MUX2  = 12;
  localparam int T_AND2  = 6;
  localparam int T_OR2   = 6;
  localparam int T_XOR2  = 12;
  localparam int T_FA    = 28;

  localparam int N_STORAGE = DEPTH * DW * (T_DFF + T_MUX2);
  localparam int N_RDMUX   = (DEPTH - 1) * DW * T_MUX2;
  localparam int N_OGATE   = DW * T_AND2;
  localparam int N_WDEC    = DEPTH * T_AND2;
  localparam int N_PTRS    = 2 * AW * (T_DFF + T_XOR2);
  localparam int N_COUNT   = CW * (T_DFF + T_FA);
  localparam int N_OVF     = T_DFF + T_OR2;
  localparam int N_CTRL    = 8 * T_AND2;
  localparam int N_TOTAL   = N_STORAGE + N_RDMUX + N_OGATE + N_WDEC
                           + N_PTRS + N_COUNT + N_OVF + N_CTRL;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = w_valid && i_out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_push  = i_in_valid && (!w_full || w_pop);
  assign w_drop  = i_in_valid && w_full && !w_pop;

  // Storage has no reset; stale entries are masked by o_out_valid.
  always_ff @(posedge clk) begin
    if (rst_n && !i_flush && w_push) begin
      r_mem[r_wr_ptr] <= i_y;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_out_valid = w_valid;
  assign o_y         = w_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count     = r_count;
  assign o_overflow  = r_overflow;
  assign number      = 51'(N_TOTAL);

endmodule

// File: tb/tb_sigmoid_out_fifo.sv
// Self-checking bench for sigmoid_out_fifo: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_sigmoid_out_fifo;

  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int CW    = 3;

  logic          clk;
  logic          rst_n;
  logic          i_in_valid;
  logic [DW-1:0] i_y;
  logic          i_flush;
  logic          i_out_ready;
  logic [DW-1:0] o_y;
  logic          o_out_valid;
  logic [CW-1:0] o_count;
  logic          o_overflow;
  logic [50:0]   number;

  sigmoid_out_fifo #(.DEPTH(DEPTH), .DW(DW), .CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (i_in_valid),
    .i_y         (i_y),
    .i_flush     (i_flush),
    .i_out_ready (i_out_ready),
    .o_y         (o_y),
    .o_out_valid (o_out_valid),
    .o_count     (o_count),
    .o_overflow  (o_overflow),
    .number      (number)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cyc    = 0;

  // Reference model: contents as a queue plus the sticky flag.
  logic [DW-1:0] mq[$];
  bit            m_ovf;

  function automatic logic [20:0] model_vec();
    logic [DW-1:0] y;
    y = (mq.size() != 0) ? mq[0] : '0;
    return {mq.size() != 0, 3'(mq.size()), m_ovf, y};
  endfunction

  function automatic logic [20:0] dut_vec();
    return {o_out_valid, o_count, o_overflow, o_y};
  endfunction

  // One clock: drive inputs, advance the model at the edge, settle, log.
  task automatic cycle(input bit v, input logic [DW-1:0] y, input bit rdy,
                       input bit fl, input bit rst);
    bit pop;
    i_in_valid  = v;
    i_y         = y;
    i_out_ready = rdy;
    i_flush     = fl;
    rst_n       = !rst;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (fl) begin
      mq.delete();
    end else begin
      pop = (mq.size() != 0) && rdy;
      if (pop) void'(mq.pop_front());
      if (v) begin
        if (mq.size() < DEPTH) mq.push_back(y);
        else m_ovf = 1'b1;
      end
    end
    #1;
    n_cyc++;
    $display("cyc %0d: rst=%0b fl=%0b in_v=%0b y=%h rdy=%0b -> valid=%0b count=%0d ovf=%0b o_y=%h",
             n_cyc, rst, fl, v, y, rdy, o_out_valid, o_count, o_overflow, o_y);
  endtask

  task automatic do_reset();
    cycle(0, '0, 0, 0, 1);
    cycle(0, '0, 0, 0, 1);
  endtask

  task automatic test_reset();
    do_reset();
    cycle(0, '0, 0, 0, 0);
    n_checks++;
    if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", o_out_valid); end
    n_checks++;
    if (o_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", o_count); end
    n_checks++;
    if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b want 0", o_overflow); end
    n_checks++;
    if (o_y !== 16'h0000) begin n_fail++; $display("FAIL reset_y: got %h want 0000", o_y); end
    // 64*36 + 48*12 + 16*6 + 4*6 + 4*36 + 3*52 + 30 + 48 for the default sizing
    n_checks++;
    if (number !== 51'd3378) begin n_fail++; $display("FAIL number: got %0d want 3378", number); end
  endtask

  task automatic test_pass_through();
    do_reset();
    cycle(1, 16'h7F00, 1, 0, 0);
    n_checks++;
    if (o_out_valid !== 1'b1 || o_y !== 16'h7F00) begin
      n_fail++; $display("FAIL pass_out: got v=%0b y=%h want v=1 y=7f00", o_out_valid, o_y);
    end
    cycle(0, '0, 1, 0, 0);
    n_checks++;
    if (o_out_valid !== 1'b0 || o_y !== 16'h0000) begin
      n_fail++; $display("FAIL pass_drained: got v=%0b y=%h want v=0 y=0000", o_out_valid, o_y);
    end
  endtask

  task automatic test_fill_overflow();
    logic [DW-1:0] want;
    do_reset();
    for (int k = 1; k <= 4; k++) cycle(1, 16'(k << 8), 0, 0, 0);
    n_checks++;
    if (o_count !== 3'd4 || o_overflow !== 1'b0) begin
      n_fail++; $display("FAIL fill_full: got count=%0d ovf=%0b want 4/0", o_count, o_overflow);
    end
    cycle(1, 16'h0500, 0, 0, 0);
    n_checks++;
    if (o_count !== 3'd4 || o_overflow !== 1'b1) begin
      n_fail++; $display("FAIL fill_drop: got count=%0d ovf=%0b want 4/1", o_count, o_overflow);
    end
    for (int k = 1; k <= 4; k++) begin
      want = 16'(k << 8);
      n_checks++;
      if (o_out_valid !== 1'b1 || o_y !== want) begin
        n_fail++; $display("FAIL fill_drain: got v=%0b y=%h want v=1 y=%h", o_out_valid, o_y, want);
      end
      cycle(0, '0, 1, 0, 0);
    end
    n_checks++;
    if (o_count !== 3'd0 || o_overflow !== 1'b1) begin
      n_fail++; $display("FAIL fill_after: got count=%0d ovf=%0b want 0/1", o_count, o_overflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic [DW-1:0] order [4];
    order = '{16'h0200, 16'h0300, 16'h0400, 16'h0600};
    do_reset();
    for (int k = 1; k <= 4; k++) cycle(1, 16'(k << 8), 0, 0, 0);
    cycle(1, 16'h0600, 1, 0, 0);
    n_checks++;
    if (o_count !== 3'd4 || o_overflow !== 1'b0) begin
      n_fail++; $display("FAIL fullpp_state: got count=%0d ovf=%0b want 4/0", o_count, o_overflow);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (o_out_valid !== 1'b1 || o_y !== order[k]) begin
        n_fail++; $display("FAIL fullpp_drain: got v=%0b y=%h want v=1 y=%h", o_out_valid, o_y, order[k]);
      end
      cycle(0, '0, 1, 0, 0);
    end
  endtask

  task automatic test_streaming();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(1, 16'(i << 8), 1, 0, 0);
      n_checks++;
      if (o_count !== 3'd1 || o_out_valid !== 1'b1 || o_y !== 16'(i << 8)) begin
        n_fail++; $display("FAIL stream: got count=%0d v=%0b y=%h want 1/1/%h",
                           o_count, o_out_valid, o_y, 16'(i << 8));
      end
    end
  endtask

  task automatic test_flush_reset();
    do_reset();
    for (int k = 1; k <= 5; k++) cycle(1, 16'(k << 8), 0, 0, 0);
    cycle(0, '0, 1, 0, 0);
    n_checks++;
    if (o_count !== 3'd3 || o_overflow !== 1'b1) begin
      n_fail++; $display("FAIL flush_setup: got count=%0d ovf=%0b want 3/1", o_count, o_overflow);
    end
    cycle(1, 16'hAAAA, 0, 1, 0);
    n_checks++;
    if (o_count !== 3'd0 || o_out_valid !== 1'b0 || o_overflow !== 1'b1 || o_y !== 16'h0000) begin
      n_fail++; $display("FAIL flush: got count=%0d v=%0b ovf=%0b y=%h want 0/0/1/0000",
                         o_count, o_out_valid, o_overflow, o_y);
    end
    cycle(1, 16'h1234, 0, 0, 0);
    cycle(1, 16'hBBBB, 0, 0, 1);
    n_checks++;
    if (dut_vec() !== 21'd0) begin
      n_fail++; $display("FAIL midreset: got %h want 000000", dut_vec());
    end
  endtask

  task automatic test_random();
    bit v, rdy, fl, rst;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 9) < 6);
      rdy = ($urandom_range(0, 9) < 5);
      fl  = ($urandom_range(0, 31) == 0);
      rst = ($urandom_range(0, 63) == 0);
      cycle(v, 16'($urandom), rdy, fl, rst);
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL random: got {v,cnt,ovf,y}=%h want %h", dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; i_in_valid = 1'b0; i_y = '0; i_flush = 1'b0; i_out_ready = 1'b0;
    m_ovf = 1'b0;
    test_reset();
    test_pass_through();
    test_fill_overflow();
    test_full_push_pop();
    test_streaming();
    test_flush_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sigmoid_out_fifo.md
Name: sigmoid_out_fifo

Overview:
- Downstream stage of the sigmoid block; captures its o_y / o_out_valid stream.
- The sigmoid stage has no backpressure, so this block buffers results in a small first-word-fall-through FIFO.
- Presents the buffered results to the consumer over a valid/ready handshake.
- Reports occupancy and a sticky overflow flag, plus the transistor-count "number" output used across the design.

Parameters:
- DEPTH, 4, number of 16-bit entries; power of two, >= 2.
- DW, 16, data width; matches the sigmoid o_y width.
- CW, 3, occupancy counter width; equals log2(DEPTH)+1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- i_in_valid  input  1  sample strobe from the sigmoid stage (its o_out_valid).
- i_y  input  DW  sample data from the sigmoid stage (its o_y).
- i_flush  input  1  synchronous flush; empties the FIFO and keeps o_overflow.
- i_out_ready  input  1  consumer ready.
- o_y  output  DW  head-of-FIFO data.
- o_out_valid  output  1  head entry is valid.
- o_count  output  CW  current occupancy, 0..DEPTH.
- o_overflow  output  1  sticky: a sample was dropped because the FIFO was full.
- number  output  51  total transistor count of all instantiated cells.

Behaviour:
- Reset (rst_n=0 at a rising edge) sets the following:
  - rd_ptr=0, wr_ptr=0, count=0.
  - o_out_valid=0, o_count=0, o_overflow=0, o_y=0.
- Reset overrides every other input in that cycle, and it may arrive mid-stream. Entries in storage need not be cleared; they are never exposed while o_out_valid=0.
- Pop: occurs at an edge when o_out_valid=1 and i_out_ready=1. rd_ptr advances mod DEPTH.
- Push: occurs at an edge when i_in_valid=1 and the FIFO will accept the sample. It writes i_y to mem[wr_ptr], and wr_ptr advances mod DEPTH.
- Accept rule: accept if count<DEPTH, or if count==DEPTH and a pop happens in the same cycle. A full FIFO with a simultaneous pop accepts the push; count stays at DEPTH.
- Drop rule: i_in_valid=1 with count==DEPTH and no pop drops the sample and sets o_overflow=1. o_overflow holds until reset; flush does not clear it.
- Count update:
  - push only: +1.
  - pop only: -1.
  - both, or neither: unchanged.
  - Pop on empty is impossible because o_out_valid=0 when empty.
- Fall-through output:
  - o_out_valid = (count != 0).
  - o_y = mem[rd_ptr] when o_out_valid=1, and 0 otherwise.
  - o_y and o_out_valid are registered or decoded from registers only, with no combinational path from i_in_valid or i_y.
- Latency: a sample pushed at edge N into an empty FIFO appears on o_y with o_out_valid=1 in the cycle after edge N (1-cycle latency).
- Ordering: strictly FIFO. Pointers wrap from DEPTH-1 to 0 with no gaps.
- i_flush=1 at an edge sets rd_ptr=wr_ptr=0 and count=0.
  - Any push or pop in that same cycle is ignored; the sample is discarded and does not set overflow.
  - rst_n takes priority over i_flush.
- o_count = count.
- number is a constant equal to the sum of the counts of all sub-cells, including the storage registers, pointers, counter, overflow flag and logic gates.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles then 1, no input -> o_out_valid=0, o_count=0, o_overflow=0, o_y=0.
- Single pass-through: push i_y=16'h7F00 at edge 1, i_out_ready=1 -> o_out_valid=1 with o_y=16'h7F00 after edge 1; popped at edge 2; o_out_valid=0 after edge 2.
- Fill and overflow: i_out_ready=0, push 16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500 on consecutive edges.
  - o_count reaches 4; 16'h0500 is dropped and o_overflow=1.
  - Draining then yields 0100, 0200, 0300, 0400, and o_overflow stays 1.
- Full with simultaneous push and pop: FIFO full with 0100..0400; at one edge i_in_valid=1 with i_y=16'h0600 and i_out_ready=1.
  - o_count stays 4 and o_overflow stays 0.
  - Drain order is 0200, 0300, 0400, 0600, exercising wrap-around.
- Streaming: continuous pushes of 16'h0000, 16'h0100, ... with i_out_ready=1 for 10 cycles -> o_count stays at 1 and the output sequence matches the input delayed by 1 cycle.
- Flush and reset mid-stream:
  - With 3 entries and o_overflow=1, i_flush=1 together with a push -> o_count=0, o_out_valid=0, o_overflow=1.
  - Then rst_n=0 for one edge together with a push -> all outputs 0.
